sim_uart_lite: RTL and testbench

Simulation-only UartLite-compatible console device. It sits between the SoC's MMIO UART port inside `SimTop` and the top-level console pins (`io_uart_out_*` / `io_uart_in_*`). It buffers CPU-written bytes in a TX FIFO and drains them to the console one byte per pulse. It also periodically polls the console input, queues received bytes in an RX FIFO, and exposes status, control and interrupt to the CPU through a single-outstanding register port.

---
 rtl/sim_uart_lite.sv | 203 ++++++++++++++++++++
 tb/tb_sim_uart_lite.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_uart_lite.sv
// Simulation-only UartLite-compatible console: CPU writes drain to the console one
// byte per pulse, console input is polled into an RX FIFO, status/irq via a register port.
module sim_uart_lite #(
    parameter int unsigned TX_DEPTH      = 16,
    parameter int unsigned RX_DEPTH      = 16,
    parameter int unsigned TX_GAP        = 0,
    parameter int unsigned POLL_INTERVAL = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        uart_out_valid,
    output logic [7:0]  uart_out_ch,
    output logic        uart_in_valid,
    input  logic [7:0]  uart_in_ch,
    output logic        irq
);
    localparam int unsigned TX_AW  = $clog2(TX_DEPTH);
    localparam int unsigned TX_PW  = TX_AW + 1;
    localparam int unsigned RX_AW  = $clog2(RX_DEPTH);
    localparam int unsigned RX_PW  = RX_AW + 1;
    localparam int unsigned RX_CW  = RX_PW + 1;
    localparam int unsigned GAP_W  = (TX_GAP < 1) ? 1 : $clog2(TX_GAP + 1);
    localparam int unsigned POLL_W = (POLL_INTERVAL < 2) ? 1 : $clog2(POLL_INTERVAL);

    localparam logic [3:0]        ADDR_RX     = 4'h0;
    localparam logic [3:0]        ADDR_TX     = 4'h4;
    localparam logic [3:0]        ADDR_STAT   = 4'h8;
    localparam logic [3:0]        ADDR_CTRL   = 4'hC;
    localparam logic [GAP_W-1:0]  GAP_RELOAD  = GAP_W'(TX_GAP);
    localparam logic [POLL_W-1:0] POLL_RELOAD = POLL_W'(POLL_INTERVAL - 1);

    logic [7:0]        tx_mem [TX_DEPTH];
    logic [7:0]        rx_mem [RX_DEPTH];
    logic [TX_PW-1:0]  tx_wr, tx_rd, tx_wr_n, tx_rd_n;
    logic [RX_PW-1:0]  rx_wr, rx_rd, rx_wr_n, rx_rd_n;
    logic [RX_PW-1:0]  rx_count;
    logic [RX_CW-1:0]  rx_occ;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
    logic [POLL_W-1:0] poll_cnt, poll_cnt_n;
    logic              intr_en, intr_en_n;
    logic              tx_drop, tx_drop_n;

    logic        accept, wr_acc, rd_acc;
    logic        sel_rx, sel_tx, sel_stat, sel_ctrl;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic        tx_flush, rx_flush;
    logic        tx_push_req, tx_push, tx_pop;
    logic        rx_push, rx_pop, stat_rd;
    logic        poll_hit, poll_ok;
    logic [7:0]  tx_head;
    logic [31:0] rdata_c;
    logic        unused_wdata;

    assign unused_wdata = ^req_wdata[31:8];

    // Register port handshake and address decode
    assign req_ready = !resp_valid || resp_ready;
    assign accept    = req_valid && req_ready;
    assign wr_acc    = accept && req_wen;
    assign rd_acc    = accept && !req_wen;
    assign sel_rx    = (req_addr == ADDR_RX);
    assign sel_tx    = (req_addr == ADDR_TX);
    assign sel_stat  = (req_addr == ADDR_STAT);
    assign sel_ctrl  = (req_addr == ADDR_CTRL);

    assign tx_empty = (tx_wr == tx_rd);
    assign tx_full  = (tx_wr[TX_AW] != tx_rd[TX_AW]) && (tx_wr[TX_AW-1:0] == tx_rd[TX_AW-1:0]);
    assign rx_empty = (rx_wr == rx_rd);
    assign rx_full  = (rx_wr[RX_AW] != rx_rd[RX_AW]) && (rx_wr[RX_AW-1:0] == rx_rd[RX_AW-1:0]);
    assign rx_count = rx_wr - rx_rd;

    // Event decode; a flush overrides any push/pop on the same FIFO
    always_comb begin
        tx_flush    = wr_acc && sel_ctrl && req_wdata[0];
        rx_flush    = wr_acc && sel_ctrl && req_wdata[1];
        tx_push_req = wr_acc && sel_tx;
        tx_push     = tx_push_req && !tx_full && !tx_flush;
        // An empty FIFO forwards the incoming byte so it leaves on the next cycle
        tx_head     = tx_empty ? req_wdata[7:0] : tx_mem[tx_rd[TX_AW-1:0]];
        tx_pop      = (gap_cnt == '0) && (!tx_empty || tx_push) && !tx_flush;
        rx_push     = uart_in_valid && (uart_in_ch != 8'hFF) && !rx_full && !rx_flush;
        rx_pop      = rd_acc && sel_rx && !rx_empty && !rx_flush;
        stat_rd     = rd_acc && sel_stat;
        poll_hit    = (poll_cnt == '0);
        // Count a poll already in flight so RX can never overflow
        rx_occ      = RX_CW'(rx_count) + RX_CW'(uart_in_valid);
        poll_ok     = (rx_occ < RX_CW'(RX_DEPTH));
    end

    // Next-state values for pointers, counters and control flags
    always_comb begin
        tx_wr_n    = tx_wr + TX_PW'(tx_push);
        tx_rd_n    = tx_rd + TX_PW'(tx_pop);
        rx_wr_n    = rx_wr + RX_PW'(rx_push);
        rx_rd_n    = rx_rd + RX_PW'(rx_pop);
        gap_cnt_n  = gap_cnt;
        poll_cnt_n = poll_cnt - POLL_W'(1);
        intr_en_n  = intr_en;
        tx_drop_n  = tx_drop;
        if (tx_flush) begin
            tx_wr_n = '0;
            tx_rd_n = '0;
        end
        if (rx_flush) begin
            rx_wr_n = '0;
            rx_rd_n = '0;
        end
        if (tx_pop) begin
            gap_cnt_n = GAP_RELOAD;
        end else if (gap_cnt != '0) begin
            gap_cnt_n = gap_cnt - GAP_W'(1);
        end
        if (poll_hit) begin
            poll_cnt_n = POLL_RELOAD;
        end
        if (wr_acc && sel_ctrl) begin
            intr_en_n = req_wdata[4];
        end
        if (tx_push_req && tx_full) begin
            tx_drop_n = 1'b1;
        end else if (stat_rd) begin
            tx_drop_n = 1'b0;
        end
    end

    // Read data mux; STAT reports tx_drop before the read clears it
    always_comb begin
        rdata_c = '0;
        if (!req_wen) begin
            case (req_addr)
                ADDR_RX: begin
                    if (!rx_empty && !rx_flush) begin
                        rdata_c = {24'h0, rx_mem[rx_rd[RX_AW-1:0]]};
                    end
                end
                ADDR_STAT: rdata_c = {26'h0, tx_drop, intr_en, tx_full, tx_empty, rx_full, !rx_empty};
                default:   rdata_c = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_wr          <= '0;
            tx_rd          <= '0;
            rx_wr          <= '0;
            rx_rd          <= '0;
            gap_cnt        <= '0;
            poll_cnt       <= POLL_RELOAD;
            intr_en        <= 1'b0;
            tx_drop        <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            uart_out_valid <= 1'b0;
            uart_out_ch    <= '0;
            uart_in_valid  <= 1'b0;
            irq            <= 1'b0;
        end else begin
            tx_wr          <= tx_wr_n;
            tx_rd          <= tx_rd_n;
            rx_wr          <= rx_wr_n;
            rx_rd          <= rx_rd_n;
            gap_cnt        <= gap_cnt_n;
            poll_cnt       <= poll_cnt_n;
            intr_en        <= intr_en_n;
            tx_drop        <= tx_drop_n;
            if (accept) begin
                resp_valid <= 1'b1;
                resp_rdata <= rdata_c;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
            uart_out_valid <= tx_pop;
            if (tx_pop) begin
                uart_out_ch <= tx_head;
            end
            uart_in_valid  <= poll_hit && poll_ok;
            irq            <= intr_en_n && (rx_wr_n != rx_rd_n);
        end
    end

    // FIFO storage; emptiness is tracked by the pointers alone
    always_ff @(posedge clock) begin
        if (tx_push) begin
            tx_mem[tx_wr[TX_AW-1:0]] <= req_wdata[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (rx_push) begin
            rx_mem[rx_wr[RX_AW-1:0]] <= uart_in_ch;
        end
    end

endmodule

// File: tb/tb_sim_uart_lite.sv
// Directed bench for sim_uart_lite: register port, TX drain/drop/flush, RX polling/irq, reset.
module tb_sim_uart_lite;
    localparam int unsigned TXD  = 4;
    localparam int unsigned RXD  = 4;
    localparam int unsigned GAP  = 2;
    localparam int unsigned POLL = 8;

    localparam logic [7:0] DROP_CH  [7] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h17};
    localparam int         DROP_CYC [7] = '{1, 4, 7, 10, 13, 16, 19};

    logic        clock, reset;
    logic        req_valid, req_ready, req_wen;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata, resp_rdata;
    logic        resp_valid, resp_ready;
    logic        uart_out_valid, uart_in_valid, irq;
    logic [7:0]  uart_out_ch, uart_in_ch;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] out_ch [$];
    int         out_cyc [$];

    sim_uart_lite #(
        .TX_DEPTH(TXD), .RX_DEPTH(RXD), .TX_GAP(GAP), .POLL_INTERVAL(POLL)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .uart_out_valid(uart_out_valid), .uart_out_ch(uart_out_ch),
        .uart_in_valid(uart_in_valid), .uart_in_ch(uart_in_ch), .irq(irq)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Console side: log every emitted byte with its cycle
    always @(negedge clock) begin
        if (uart_out_valid) begin
            out_ch.push_back(uart_out_ch);
            out_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_wr(input logic [3:0] a, input logic [31:0] w);
        @(negedge clock);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = a;
        req_wdata = w;
    endtask

    task automatic idle();
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] w);
        drive_wr(a, w);
        idle();
        check("wr_resp_valid", resp_valid, 1);
        check("wr_resp_rdata", resp_rdata, 0);
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clock);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = a;
        req_wdata = '0;
        @(negedge clock);
        req_valid = 1'b0;
        check("rd_resp_valid", resp_valid, 1);
        d = resp_rdata;
    endtask

    task automatic wait_poll(output bit got);
        got = 1'b0;
        for (int i = 0; i < 2 * POLL; i++) begin
            @(negedge clock);
            if (uart_in_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_out(input string tag, input int idx, input logic [7:0] ch, input int at);
        if (out_ch.size() > idx) begin
            check({tag, "_ch"}, 32'(out_ch[idx]), 32'(ch));
            check({tag, "_cyc"}, out_cyc[idx], at);
        end
    endtask

    initial begin
        logic [31:0] d;
        int t0, base;
        bit got, seen;

        reset = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
        req_wdata = '0; resp_ready = 1'b1; uart_in_ch = 8'hFF;
        repeat (3) @(negedge clock);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_out_valid", uart_out_valid, 0);
        check("rst_out_ch", uart_out_ch, 0);
        check("rst_in_valid", uart_in_valid, 0);
        check("rst_irq", irq, 0);

        // First poll lands POLL cycles after release
        reset = 1'b1;
        t0 = cyc;
        wait_poll(got);
        check("first_poll_seen", got, 1);
        check("first_poll_cyc", cyc, t0 + POLL);

        // Two back-to-back bytes
        base = out_ch.size();
        drive_wr(4'h4, 32'h48);
        t0 = cyc;
        drive_wr(4'h4, 32'h69);
        idle();
        repeat (8) @(negedge clock);
        check("hi_count", out_ch.size(), base + 2);
        check_out("hi0", base, 8'h48, t0 + 1);
        check_out("hi1", base + 1, 8'h69, t0 + 1 + 1 + GAP);
        reg_read(4'h8, d);
        check("hi_stat", d, 32'h04);

        // Eight writes into a depth-4 FIFO: 0x16 meets a full FIFO as a pop happens
        base = out_ch.size();
        for (int i = 0; i < 8; i++) begin
            drive_wr(4'h4, 32'h10 + 32'(i));
            if (i == 0) t0 = cyc;
        end
        reg_read(4'h8, d);
        check("drop_stat1", d, 32'h28);
        reg_read(4'h8, d);
        check("drop_stat2", d, 32'h00);
        repeat (15) @(negedge clock);
        check("drop_count", out_ch.size(), base + 7);
        for (int k = 0; k < 7; k++) check_out("drop", base + k, DROP_CH[k], t0 + DROP_CYC[k]);

        // Register map corners
        reg_write(4'h0, 32'h77);
        reg_read(4'h0, d);
        check("rx_empty_read", d, 0);
        reg_read(4'h4, d);
        check("tx_read", d, 0);
        reg_read(4'hC, d);
        check("ctrl_read", d, 0);
        reg_read(4'h8, d);
        check("idle_stat", d, 32'h04);

        // Response held while resp_ready is low
        resp_ready = 1'b0;
        @(negedge clock);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 4'h8;
        @(negedge clock);
        req_valid = 1'b0;
        check("hold_valid0", resp_valid, 1);
        check("hold_ready0", req_ready, 0);
        check("hold_rdata", resp_rdata, 32'h04);
        @(negedge clock);
        check("hold_valid1", resp_valid, 1);
        resp_ready = 1'b1;
        @(negedge clock);
        check("hold_release", resp_valid, 0);
        check("hold_ready1", req_ready, 1);

        // One console byte with interrupts enabled
        reg_write(4'hC, 32'h10);
        wait_poll(got);
        check("rx_poll_seen", got, 1);
        check("irq_at_poll", irq, 0);
        uart_in_ch = 8'h41;
        @(negedge clock);
        uart_in_ch = 8'hFF;
        check("irq_after_push", irq, 1);
        reg_read(4'h8, d);
        check("rx_stat", d, 32'h15);
        reg_read(4'h0, d);
        check("rx_data", d, 32'h41);
        check("irq_after_pop", irq, 0);
        reg_read(4'h0, d);
        check("rx_again", d, 0);

        // Fill RX, polling must stop until space frees
        uart_in_ch = 8'h55;
        for (int k = 0; k < RXD; k++) begin
            wait_poll(got);
            check("fill_poll", got, 1);
        end
        @(negedge clock);
        reg_read(4'h8, d);
        check("full_stat", d, 32'h17);
        seen = 1'b0;
        repeat (3 * POLL) begin
            @(negedge clock);
            if (uart_in_valid) seen = 1'b1;
        end
        check("full_no_poll", seen, 0);
        reg_read(4'h0, d);
        check("full_pop", d, 32'h55);
        wait_poll(got);
        check("poll_resumes", got, 1);
        uart_in_ch = 8'hFF;

        // Flush both FIFOs while TX still holds bytes
        base = out_ch.size();
        for (int i = 0; i < 5; i++) begin
            drive_wr(4'h4, 32'h20 + 32'(i));
            if (i == 0) t0 = cyc;
        end
        drive_wr(4'hC, 32'h3);
        idle();
        repeat (12) @(negedge clock);
        check("flush_count", out_ch.size(), base + 2);
        check_out("flush0", base, 8'h20, t0 + 1);
        check_out("flush1", base + 1, 8'h21, t0 + 4);
        reg_read(4'h8, d);
        check("flush_stat", d, 32'h04);
        check("flush_irq", irq, 0);

        // Reset in the middle of a drain
        base = out_ch.size();
        for (int i = 0; i < 6; i++) begin
            drive_wr(4'h4, 32'h30 + 32'(i));
            if (i == 0) t0 = cyc;
        end
        @(negedge clock);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_out_valid", uart_out_valid, 0);
        check("mid_rst_out_ch", uart_out_ch, 0);
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_rdata", resp_rdata, 0);
        check("mid_rst_in_valid", uart_in_valid, 0);
        check("mid_rst_irq", irq, 0);
        check("mid_rst_req_ready", req_ready, 1);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        check("mid_rst_count", out_ch.size(), base + 2);
        check_out("mid_rst0", base, 8'h30, t0 + 1);
        check_out("mid_rst1", base + 1, 8'h31, t0 + 4);
        reg_read(4'h8, d);
        check("mid_rst_stat", d, 32'h04);
        base = out_ch.size();
        drive_wr(4'h4, 32'h5A);
        t0 = cyc;
        idle();
        repeat (4) @(negedge clock);
        check("post_rst_count", out_ch.size(), base + 1);
        check_out("post_rst", base, 8'h5A, t0 + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
